// File: rtl/uart_boot_loader.sv
// Purpose:      frames a UART byte stream into 32-bit instruction-memory writes and
//               holds the core in reset while a program image is loading.
// Latency:      each imem write strobes one cycle after the 4th byte of its word;
//               the status byte is presented one cycle after the checksum byte.
// Backpressure: the status byte is held on tx_valid/tx_data until tx_ready. There is
//               no rx backpressure, and bytes arriving while the status is pending are dropped.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   rx_valid, rx_data            received byte strobe and data
//   tx_ready, tx_valid, tx_data  status byte handshake ('K' ok / 'E' error)
//   imem_wr_en/addr/data         one-cycle word write into instruction memory
//   core_rst                     active-high core hold
//   busy                         frame in progress or status pending
//   error                        sticky, last frame failed
module uart_boot_loader #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int unsigned MAX_WORDS    = 4096,
  parameter int unsigned IDLE_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        imem_wr_en,
  output logic [31:0] imem_wr_addr,
  output logic [31:0] imem_wr_data,
  output logic        core_rst,
  output logic        busy,
  output logic        error
);

  localparam int unsigned  TW       = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(IDLE_TIMEOUT - 1);
  localparam logic [7:0]   SYNC     = 8'hA5;
  localparam logic [7:0]   RSP_OK   = 8'h4B;
  localparam logic [7:0]   RSP_ERR  = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [15:0]   word_idx;
  logic [1:0]    byte_cnt;
  logic [7:0]    csum;
  logic [23:0]   word_asm;   // lower three bytes; the 4th byte goes straight to imem_wr_data
  logic [TW-1:0] tmo_cnt;

  logic          resp_load;
  logic [7:0]    resp_byte;

  // Frame-level decode shared by the FSM and the datapath
  logic          active;
  logic          tmo_hit;
  logic [15:0]   len_rx;
  logic          len_bad;
  logic          word_done;
  logic          last_word;

  assign active    = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                     (state == S_DATA)   || (state == S_CSUM);
  // A byte arriving in the expiry cycle counts as activity.
  assign tmo_hit   = active && !rx_valid && (tmo_cnt == TMO_LAST);
  assign len_rx    = {rx_data, len_lo};
  assign len_bad   = (len_rx == 16'd0) || (32'(len_rx) > MAX_WORDS);
  assign word_done = (byte_cnt == 2'd3);
  assign last_word = (word_idx == (len - 16'd1));

  assign tx_valid  = (state == S_RESP);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    resp_load = 1'b0;
    resp_byte = RSP_ERR;
    case (state)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC)) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (rx_valid) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          if (len_bad) begin
            state_nxt = S_RESP;
            resp_load = 1'b1;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid && word_done && last_word) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        if (rx_valid) begin
          state_nxt = S_RESP;
          resp_load = 1'b1;
          resp_byte = (rx_data == csum) ? RSP_OK : RSP_ERR;
        end
      end
      S_RESP: begin
        if (tx_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (tmo_hit) begin
      state_nxt = S_RESP;
      resp_load = 1'b1;
      resp_byte = RSP_ERR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo       <= 8'd0;
      len          <= 16'd0;
      word_idx     <= 16'd0;
      byte_cnt     <= 2'd0;
      csum         <= 8'd0;
      word_asm     <= 24'd0;
      tmo_cnt      <= '0;
      tx_data      <= 8'd0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= BASE_ADDR;
      imem_wr_data <= 32'd0;
      core_rst     <= 1'b0;
      error        <= 1'b0;
    end else begin
      imem_wr_en <= 1'b0;

      if (active && !rx_valid) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end

      case (state)
        S_IDLE: begin
          if (rx_valid && (rx_data == SYNC)) begin
            core_rst <= 1'b1;
            word_idx <= 16'd0;
            byte_cnt <= 2'd0;
            csum     <= 8'd0;
            word_asm <= 24'd0;
          end
        end
        S_LEN_LO: begin
          if (rx_valid) len_lo <= rx_data;
        end
        S_LEN_HI: begin
          if (rx_valid) len <= len_rx;
        end
        S_DATA: begin
          if (rx_valid) begin
            csum     <= csum + rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0:    word_asm[7:0]   <= rx_data;
              2'd1:    word_asm[15:8]  <= rx_data;
              2'd2:    word_asm[23:16] <= rx_data;
              default: ;
            endcase
            if (word_done) begin
              imem_wr_en   <= 1'b1;
              imem_wr_addr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
              imem_wr_data <= {rx_data, word_asm};
              word_idx     <= word_idx + 16'd1;
            end
          end
        end
        S_RESP: begin
          // A failed frame leaves memory partially written, so the core stays held.
          if (tx_ready) begin
            if (tx_data == RSP_OK) begin
              core_rst <= 1'b0;
              error    <= 1'b0;
            end else begin
              error    <= 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (resp_load) tx_data <= resp_byte;
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Purpose:      directed, table-driven check of uart_boot_loader framing, writes and status.
// Latency:      n/a (testbench).
// Backpressure: drives tx_ready high except in the held-status sequence.
module tb_uart_boot_loader;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        imem_wr_en;
  logic [31:0] imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic        core_rst;
  logic        busy;
  logic        error;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];

  uart_boot_loader #(
    .BASE_ADDR   (32'h8000_0000),
    .MAX_WORDS   (4096),
    .IDLE_TIMEOUT(100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_ready    (tx_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .imem_wr_en  (imem_wr_en),
    .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data),
    .core_rst    (core_rst),
    .busy        (busy),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write strobes last exactly one cycle, so each is seen at exactly one negedge.
  always @(negedge clk) begin
    if (imem_wr_en === 1'b1) begin
      wr_a.push_back(imem_wr_addr);
      wr_d.push_back(imem_wr_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        name;
    logic [159:0] bytes;  // first byte sent is the most significant of the n used
    int           n;
    int           nwr;
    logic [31:0]  a0, d0, a1, d1;
    logic [7:0]   tx;
    logic         crst;
    logic         err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int limit, output int cyc);
    cyc = 0;
    while (tx_valid !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    wr_a.delete();
    wr_d.delete();
    tx_ready = 1'b1;
    for (int k = 0; k < v.n; k++) send_byte(v.bytes[8*(v.n-1-k) +: 8]);
    wait_tx(200, cyc);
    chk({v.name, "_tx_seen"}, {31'd0, tx_valid}, 32'd1);
    chk({v.name, "_tx_data"}, {24'd0, tx_data}, {24'd0, v.tx});
    chk({v.name, "_core_rst_in_resp"}, {31'd0, core_rst}, 32'd1);
    @(negedge clk);
    chk({v.name, "_post_tx_valid_busy"}, {30'd0, tx_valid, busy}, 32'd0);
    chk({v.name, "_core_rst"}, {31'd0, core_rst}, {31'd0, v.crst});
    chk({v.name, "_error"}, {31'd0, error}, {31'd0, v.err});
    chk({v.name, "_wr_count"}, wr_a.size(), v.nwr);
    if (v.nwr > 0 && wr_a.size() > 0) begin
      chk({v.name, "_wr0_addr"}, wr_a[0], v.a0);
      chk({v.name, "_wr0_data"}, wr_d[0], v.d0);
    end
    if (v.nwr > 1 && wr_a.size() > 1) begin
      chk({v.name, "_wr1_addr"}, wr_a[1], v.a1);
      chk({v.name, "_wr1_data"}, wr_d[1], v.d1);
    end
  endtask

  initial begin
    int cyc;
    int bad;

    vecs[0] = '{"good",      160'hA5_02_00_13_00_00_00_6F_00_00_00_82, 12, 2,
                32'h8000_0000, 32'h0000_0013, 32'h8000_0004, 32'h0000_006F, 8'h4B, 1'b0, 1'b0};
    vecs[1] = '{"bad_csum",  160'hA5_02_00_13_00_00_00_6F_00_00_00_83, 12, 2,
                32'h8000_0000, 32'h0000_0013, 32'h8000_0004, 32'h0000_006F, 8'h45, 1'b1, 1'b1};
    vecs[2] = '{"good_again", 160'hA5_02_00_13_00_00_00_6F_00_00_00_82, 12, 2,
                32'h8000_0000, 32'h0000_0013, 32'h8000_0004, 32'h0000_006F, 8'h4B, 1'b0, 1'b0};
    vecs[3] = '{"len_zero",  160'hA5_00_00, 3, 0,
                32'h0, 32'h0, 32'h0, 32'h0, 8'h45, 1'b1, 1'b1};
    vecs[4] = '{"len_4097",  160'hA5_01_10, 3, 0,
                32'h0, 32'h0, 32'h0, 32'h0, 8'h45, 1'b1, 1'b1};
    vecs[5] = '{"garbage",   160'h00_FF_5A_A5_02_00_13_00_00_00_6F_00_00_00_82, 15, 2,
                32'h8000_0000, 32'h0000_0013, 32'h8000_0004, 32'h0000_006F, 8'h4B, 1'b0, 1'b0};
    vecs[6] = '{"le_word",   160'hA5_01_00_78_56_34_12_14, 8, 1,
                32'h8000_0000, 32'h1234_5678, 32'h0, 32'h0, 8'h4B, 1'b0, 1'b0};
    vecs[7] = '{"csum_wrap", 160'hA5_01_00_FF_FF_FF_FF_FC, 8, 1,
                32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 8'h4B, 1'b0, 1'b0};

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid",   {31'd0, tx_valid},   32'd0);
    chk("rst_tx_data",    {24'd0, tx_data},    32'd0);
    chk("rst_wr_en",      {31'd0, imem_wr_en}, 32'd0);
    chk("rst_wr_addr",    imem_wr_addr,        32'h8000_0000);
    chk("rst_wr_data",    imem_wr_data,        32'd0);
    chk("rst_core_rst",   {31'd0, core_rst},   32'd0);
    chk("rst_busy",       {31'd0, busy},       32'd0);
    chk("rst_error",      {31'd0, error},      32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Timeout: stall after the first data byte; the status appears 100 cycles later.
    wr_a.delete();
    wr_d.delete();
    send_byte(8'hA5);
    chk("sync_core_rst", {31'd0, core_rst}, 32'd1);
    chk("sync_busy",     {31'd0, busy},     32'd1);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    wait_tx(300, cyc);
    chk("tmo_cycles",  cyc, 32'd100);
    chk("tmo_tx_data", {24'd0, tx_data}, 32'h45);
    @(negedge clk);
    chk("tmo_wr_count", wr_a.size(), 32'd0);
    chk("tmo_error",    {31'd0, error},    32'd1);
    chk("tmo_core_rst", {31'd0, core_rst}, 32'd1);
    chk("tmo_busy",     {31'd0, busy},     32'd0);

    // LEN = MAX_WORDS is accepted (enters DATA); abandon it via timeout.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h10);
    repeat (5) @(negedge clk);
    chk("len4096_accepted", {30'd0, tx_valid, busy}, 32'd1);
    wait_tx(300, cyc);
    chk("len4096_tmo_tx", {24'd0, tx_data}, 32'h45);
    @(negedge clk);
    chk("len4096_wr_count", wr_a.size(), 32'd0);

    // Status held under backpressure; a byte arriving meanwhile is dropped.
    tx_ready = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_tx(20, cyc);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'h45) bad++;
      if (i == 20) begin
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
      end
      if (i == 21) rx_valid = 1'b0;
    end
    chk("bp_unstable_cycles", bad, 32'd0);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("bp_post_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("bp_post_busy",     {31'd0, busy},     32'd0);
    chk("bp_post_error",    {31'd0, error},    32'd1);

    // Write strobe timing, then asynchronous reset while a strobe is in flight.
    wr_a.delete();
    wr_d.delete();
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    chk("pulse_wr_en",   {31'd0, imem_wr_en}, 32'd1);
    chk("pulse_wr_addr", imem_wr_addr, 32'h8000_0000);
    chk("pulse_wr_data", imem_wr_data, 32'h4433_2211);
    @(negedge clk);
    chk("pulse_width",   {31'd0, imem_wr_en}, 32'd0);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    chk("pulse2_wr_addr", imem_wr_addr, 32'h8000_0004);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_wr_en",    {31'd0, imem_wr_en}, 32'd0);
    chk("arst_wr_addr",  imem_wr_addr,        32'h8000_0000);
    chk("arst_wr_data",  imem_wr_data,        32'd0);
    chk("arst_core_rst", {31'd0, core_rst},   32'd0);
    chk("arst_error",    {31'd0, error},      32'd0);
    chk("arst_busy",     {31'd0, busy},       32'd0);
    chk("arst_tx",       {23'd0, tx_valid, tx_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
